// File: rtl/avmm_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin tie breaking.
// A grant is held until the whole read or write burst completes.
module avmm_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 64,
  parameter int MAX_BURST = 4,
  parameter int BCW       = $clog2(MAX_BURST) + 1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [AW-1:0]     m0_address_i,
  input  logic [BCW-1:0]    m0_burstcount_i,
  input  logic              m0_read_i,
  input  logic              m0_write_i,
  input  logic [DW-1:0]     m0_writedata_i,
  input  logic [DW/8-1:0]   m0_byteenable_i,
  output logic [DW-1:0]     m0_readdata_o,
  output logic              m0_readdatavalid_o,
  output logic              m0_waitrequest_o,

  input  logic [AW-1:0]     m1_address_i,
  input  logic [BCW-1:0]    m1_burstcount_i,
  input  logic              m1_read_i,
  input  logic              m1_write_i,
  input  logic [DW-1:0]     m1_writedata_i,
  input  logic [DW/8-1:0]   m1_byteenable_i,
  output logic [DW-1:0]     m1_readdata_o,
  output logic              m1_readdatavalid_o,
  output logic              m1_waitrequest_o,

  output logic [AW-1:0]     s_address_o,
  output logic [BCW-1:0]    s_burstcount_o,
  output logic              s_read_o,
  output logic              s_write_o,
  output logic [DW-1:0]     s_writedata_o,
  output logic [DW/8-1:0]   s_byteenable_o,
  input  logic [DW-1:0]     s_readdata_i,
  input  logic              s_readdatavalid_i,
  input  logic              s_waitrequest_i,

  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANTED   = 2'd1,
    WRITE     = 2'd2,
    READ_DATA = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_q, last_d;          // 1'b1: m1 won the most recent tie
  logic [BCW-1:0] remaining_q, remaining_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;

  logic           req0_s, req1_s;
  logic           own_m1_s;
  logic [AW-1:0]  own_addr_s;
  logic [BCW-1:0] own_bc_s;
  logic [BCW-1:0] own_burst_s;
  logic           own_read_s, own_write_s;
  logic [DW-1:0]  own_wdata_s;
  logic [DW/8-1:0] own_be_s;

  logic           s_read_s, s_write_s;
  logic [AW-1:0]  s_addr_s;
  logic [BCW-1:0] s_bc_s;
  logic           rd_acc_s, wr_acc_s;
  logic           path_open_s;

  function automatic logic [BCW-1:0] eff_burst(input logic [BCW-1:0] bc);
    return (bc == '0) ? BCW'(1) : bc;
  endfunction

  assign req0_s   = m0_read_i | m0_write_i;
  assign req1_s   = m1_read_i | m1_write_i;
  assign own_m1_s = grant_q[1];

  // Select the command fields of the current owner.
  always_comb begin
    own_addr_s  = own_m1_s ? m1_address_i    : m0_address_i;
    own_bc_s    = own_m1_s ? m1_burstcount_i : m0_burstcount_i;
    own_write_s = own_m1_s ? m1_write_i      : m0_write_i;
    own_read_s  = own_m1_s ? (m1_read_i & ~m1_write_i) : (m0_read_i & ~m0_write_i);
    own_wdata_s = own_m1_s ? m1_writedata_i  : m0_writedata_i;
    own_be_s    = own_m1_s ? m1_byteenable_i : m0_byteenable_i;
    own_burst_s = eff_burst(own_bc_s);
  end

  // Slave command: live pass-through in GRANTED, latched address/count in WRITE.
  always_comb begin
    s_read_s  = 1'b0;
    s_write_s = 1'b0;
    s_addr_s  = own_addr_s;
    s_bc_s    = own_bc_s;
    case (state_q)
      GRANTED: begin
        s_read_s  = own_read_s;
        s_write_s = own_write_s;
      end
      WRITE: begin
        s_write_s = own_write_s;
        s_addr_s  = addr_q;
        s_bc_s    = bcnt_q;
      end
      default: begin
        s_read_s  = 1'b0;
        s_write_s = 1'b0;
      end
    endcase
  end

  assign rd_acc_s       = s_read_s  & ~s_waitrequest_i;
  assign wr_acc_s       = s_write_s & ~s_waitrequest_i;
  assign path_open_s    = (state_q == GRANTED) || (state_q == WRITE);

  assign s_address_o    = s_addr_s;
  assign s_burstcount_o = s_bc_s;
  assign s_read_o       = s_read_s;
  assign s_write_o      = s_write_s;
  assign s_writedata_o  = own_wdata_s;
  assign s_byteenable_o = own_be_s;

  assign m0_readdata_o  = s_readdata_i;
  assign m1_readdata_o  = s_readdata_i;

  // Only the owner sees the slave's handshake; everyone else is held off.
  always_comb begin
    m0_waitrequest_o   = ~(path_open_s & grant_q[0]) | s_waitrequest_i;
    m1_waitrequest_o   = ~(path_open_s & grant_q[1]) | s_waitrequest_i;
    m0_readdatavalid_o = (state_q == READ_DATA) & grant_q[0] & s_readdatavalid_i;
    m1_readdatavalid_o = (state_q == READ_DATA) & grant_q[1] & s_readdatavalid_i;
  end

  assign grant = grant_q;

  // Arbitration and burst tracking.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    bcnt_d      = bcnt_q;
    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        if (req0_s && req1_s) begin
          state_d = GRANTED;
          if (last_q) begin
            grant_d = 2'b01;
            last_d  = 1'b0;
          end else begin
            grant_d = 2'b10;
            last_d  = 1'b1;
          end
        end else if (req0_s) begin
          state_d = GRANTED;
          grant_d = 2'b01;
        end else if (req1_s) begin
          state_d = GRANTED;
          grant_d = 2'b10;
        end else begin
          state_d = IDLE;
        end
      end
      GRANTED: begin
        if (wr_acc_s) begin
          if (own_burst_s <= BCW'(1)) begin
            state_d     = IDLE;
            grant_d     = 2'b00;
            remaining_d = '0;
          end else begin
            state_d     = WRITE;
            remaining_d = own_burst_s - BCW'(1);
            addr_d      = own_addr_s;
            bcnt_d      = own_bc_s;
          end
        end else if (rd_acc_s) begin
          state_d     = READ_DATA;
          remaining_d = own_burst_s;
        end else begin
          state_d = GRANTED;
        end
      end
      WRITE: begin
        if (wr_acc_s) begin
          if (remaining_q <= BCW'(1)) begin
            state_d     = IDLE;
            grant_d     = 2'b00;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - BCW'(1);
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ_DATA: begin
        if (s_readdatavalid_i) begin
          if (remaining_q <= BCW'(1)) begin
            state_d     = IDLE;
            grant_d     = 2'b00;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - BCW'(1);
          end
        end else begin
          state_d = READ_DATA;
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = 2'b00;
        remaining_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      last_q      <= 1'b1;
      remaining_q <= '0;
      addr_q      <= '0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      bcnt_q      <= bcnt_d;
    end
  end

endmodule

// File: doc/avmm_arbiter.md
# avmm_arbiter

Two-master, one-slave Avalon-MM arbiter that shares a single register or memory slave (e.g. the page selector's control bus) between two requesters. Round-robin arbitration, burst-aware: a grant is held until the whole read or write burst completes, so beats from different masters never interleave. Sits between the host-side bus masters and the slave's `avmm_if.slave` port.

## Interface
- `AW`, 16, address width.
- `DW`, 64, data width; byteenable width is DW/8.
- `MAX_BURST`, 4, largest burst length; burstcount width `BCW = $clog2(MAX_BURST)+1`.
- `clock`  in  1  single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `m0`  avmm_if.slave  AW/DW/BCW  requester 0 (address, burstcount, read, write, writedata, byteenable, readdata, readdatavalid, waitrequest).
- `m1`  avmm_if.slave  AW/DW/BCW  requester 1, same signal set.
- `s`  avmm_if.master  AW/DW/BCW  shared slave.
- `grant`  out  2  one-hot current owner ({m1,m0}); 2'b00 when idle.

## Operation
- States: IDLE, GRANTED, WRITE, READ_DATA.
- A master requests when `read || write` is high. Simultaneous read and write from one master is illegal; write wins.
- IDLE: if any request, pick a winner, register `grant`, go to GRANTED. One request wins outright. Both requesting: winner is the master not recorded in `last`; `last` is updated to the winner. Reset value of `last` is m1, so m0 wins the first tie.
- GRANTED: the winner's address, burstcount, read, write, writedata and byteenable drive `s`. The winner's waitrequest = `s.waitrequest`.
  - Read accepted (`s.read && !s.waitrequest`): load `remaining` = burstcount, go to READ_DATA.
  - Write accepted: if burstcount ≤ 1, go to IDLE; else load `remaining` = burstcount−1, go to WRITE.
- WRITE: winner's write, writedata and byteenable pass through; address and burstcount stay as presented on the first beat. Each accepted beat decrements `remaining`. The beat that takes it to 0 returns to IDLE. A master dropping `write` mid-burst simply stalls; the grant is kept.
- READ_DATA: `s.read`/`s.write` forced 0. Each `s.readdatavalid` decrements `remaining`. On the beat that takes it to 0, go to IDLE.
- `readdata` is broadcast to both masters. `readdatavalid` is routed only to the granted master and is 0 to the other.
- The non-granted master always sees `waitrequest` = 1. In IDLE both masters see `waitrequest` = 1. `s.read`/`s.write` are 0 in IDLE.
- burstcount 0 is treated as 1. `remaining` is BCW bits wide and never wraps below 0.
- `readdatavalid` arriving in a state other than READ_DATA is dropped (not forwarded).

## Timing
- Reset (synchronous): state=IDLE, grant=2'b00, last=m1, remaining=0.
  - Reset outputs: `s.read`=0, `s.write`=0, `m0/m1.waitrequest`=1, `m0/m1.readdatavalid`=0.
  - Reset mid-burst abandons the burst; the next cycle is IDLE.
- Arbitration latency: a request in IDLE at cycle N gives `grant` valid and the command on `s` at N+1. Earliest acceptance is N+1 if `s.waitrequest`=0.
- Command/data muxing from master to slave is combinational in GRANTED and WRITE. `waitrequest` and `readdatavalid` back to the masters are combinational.
- After the final beat (last write accept or last readdatavalid) the next cycle is IDLE. A new grant appears one cycle after that, giving a minimum 1-cycle bubble between transactions.
- Back-to-back contention alternates strictly: m0, m1, m0, …
- A single persistent requester is re-granted every transaction.

## Test plan
- Reset: hold `reset` 2 cycles during an m0 write burst → grant=00, `s.write`=0, both waitrequest=1. The next m1 read is granted 1 cycle after the reset deasserts.
- Single write: m0 writes addr 0x10, data 0x3, burstcount 1, slave waitrequest=0 → `s` sees one write beat at cycle N+1, grant=01, IDLE at N+2.
- Tie: m0 and m1 read at the same cycle → m0 granted first. After its readdatavalid, m1 is granted and m0 keeps waitrequest=1 throughout.
- Read burst: m1 reads burstcount 4, slave returns valid on 4 non-contiguous cycles → m1 gets exactly 4 readdatavalid pulses. m0 gets none, and its pending request stays stalled until the 4th pulse.
- Write burst with stalls: m0 writes burstcount 3, slave waitrequest toggles 1,0,1,0,0 → exactly 3 beats accepted with correct writedata and byteenable order, then IDLE. m1 is not granted mid-burst.
- Fairness: both masters continuously issue single reads → grant sequence 01,10,01,10 over 4 transactions.
